// File: rtl/kernel_sysid_ext.sv
// kernel_sysid_ext: 8-word Avalon-MM identity / scratch / uptime / seconds slave.
// Fixed read latency of one cycle, no waitrequest. A read of word 4 captures the
// upper uptime bits into a shadow so software can assemble a coherent 64-bit value.
module kernel_sysid_ext #(
    parameter logic [31:0]  SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0]  TIMESTAMP   = 32'd1485236220,
    parameter logic [31:0]  VERSION     = 32'h0001_0000,
    parameter logic [31:0]  CLK_FREQ_HZ = 32'd50000000,
    parameter int unsigned  UPTIME_W    = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int unsigned           SHADOW_W = UPTIME_W - 32;
    localparam logic [31:0]           PRE_LAST = CLK_FREQ_HZ - 32'd1;
    localparam logic [UPTIME_W-1:0]   UP_ONE   = UPTIME_W'(1);

    logic [UPTIME_W-1:0] r_uptime;
    logic [SHADOW_W-1:0] r_shadow;
    logic [31:0]         r_scratch;
    logic [31:0]         r_prescaler;
    logic [31:0]         r_seconds;
    logic                r_freeze;
    logic [31:0]         r_readdata;
    logic                r_readdatavalid;

    logic                w_wr_en;
    logic                w_clear;
    logic [31:0]         w_rdata;

    // A simultaneous read wins; the write in that cycle is dropped.
    assign w_wr_en = write & ~read;
    assign w_clear = w_wr_en & (address == 3'd7) & writedata[0];

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

    // Register map decode from current (pre-edge) state.
    always_comb begin
        w_rdata = '0;
        case (address)
            3'd0:    w_rdata = SYSTEM_ID;
            3'd1:    w_rdata = TIMESTAMP;
            3'd2:    w_rdata = VERSION;
            3'd3:    w_rdata = r_scratch;
            3'd4:    w_rdata = r_uptime[31:0];
            3'd5:    w_rdata[SHADOW_W-1:0] = r_shadow;
            3'd6:    w_rdata = r_seconds;
            3'd7:    w_rdata[1] = r_freeze;
            default: w_rdata = '0;
        endcase
    end

    // Read response: one-cycle latency, data held between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            if (read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // Software-writable scratch and freeze control.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scratch <= '0;
            r_freeze  <= 1'b0;
        end else if (w_wr_en) begin
            if (address == 3'd3) begin
                r_scratch <= writedata;
            end
            if (address == 3'd7) begin
                r_freeze <= writedata[1];
            end
        end
    end

    // Uptime counter and its high-half shadow; clear overrides increment and capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_uptime <= '0;
            r_shadow <= '0;
        end else if (w_clear) begin
            r_uptime <= '0;
            r_shadow <= '0;
        end else begin
            if (!r_freeze) begin
                r_uptime <= r_uptime + UP_ONE;
            end
            if (read && (address == 3'd4)) begin
                r_shadow <= r_uptime[UPTIME_W-1:32];
            end
        end
    end

    // Seconds prescaler: one seconds tick per CLK_FREQ_HZ unfrozen cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prescaler <= '0;
            r_seconds   <= '0;
        end else if (w_clear) begin
            r_prescaler <= '0;
            r_seconds   <= '0;
        end else if (!r_freeze) begin
            if (r_prescaler == PRE_LAST) begin
                r_prescaler <= '0;
                r_seconds   <= r_seconds + 32'd1;
            end else begin
                r_prescaler <= r_prescaler + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_kernel_sysid_ext.sv
// Self-checking bench for kernel_sysid_ext (UPTIME_W=40, CLK_FREQ_HZ=10).
// The model tracks elapsed unfrozen cycles since the last clear and derives
// uptime and seconds from that count arithmetically.
module tb_kernel_sysid_ext;

    localparam logic [31:0] P_SYSID = 32'h0000_0000;
    localparam logic [31:0] P_TS    = 32'd1485236220;
    localparam logic [31:0] P_VER   = 32'h0001_0000;
    localparam longint unsigned P_FREQ = 10;

    logic        clock;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    int force_req = 0;

    // model state
    longint unsigned m_cycles  = 0;
    longint unsigned m_up_off  = 0;
    bit              m_up_known = 1;
    logic [31:0]     m_shadow  = '0;
    logic [31:0]     m_scratch = '0;
    bit              m_freeze  = 0;
    int              force_seen = 0;
    bit              exp_rdv   = 0;
    logic [31:0]     exp_data  = '0;
    bit              exp_known = 1;

    kernel_sysid_ext #(
        .SYSTEM_ID   (P_SYSID),
        .TIMESTAMP   (P_TS),
        .VERSION     (P_VER),
        .CLK_FREQ_HZ (32'd10),
        .UPTIME_W    (40)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [39:0] up);
        case (a)
            3'd0:    return P_SYSID;
            3'd1:    return P_TS;
            3'd2:    return P_VER;
            3'd3:    return m_scratch;
            3'd4:    return up[31:0];
            3'd5:    return m_shadow;
            3'd6:    return 32'(m_cycles / P_FREQ);
            default: return {30'b0, m_freeze, 1'b0};
        endcase
    endfunction

    // Model: evaluates each accepted request against the state before the edge.
    initial begin : model
        logic [39:0] up;
        bit clr;
        bit forced;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_cycles = 0; m_up_off = 0; m_up_known = 1;
                m_shadow = '0; m_scratch = '0; m_freeze = 0;
                exp_rdv = 0; exp_data = '0; exp_known = 1;
            end else begin
                forced = (force_req != force_seen);
                if (forced) begin
                    force_seen = force_req;
                    m_up_off = 64'h00FF_FFFF_FFFF - m_cycles;
                end
                up = 40'(m_cycles + m_up_off);
                exp_rdv = read;
                if (read) begin
                    exp_data  = model_read(address, up);
                    exp_known = (address != 3'd4) || m_up_known;
                    if (address == 3'd4) m_shadow = {24'h0, up[39:32]};
                end
                // after the backdoor cycle the DUT counter value depends on release semantics
                if (forced) m_up_known = 0;
                clr = write && !read && (address == 3'd7) && writedata[0];
                if (clr) begin
                    m_cycles = 0; m_up_off = 0; m_up_known = 1; m_shadow = '0;
                end else if (!m_freeze) begin
                    m_cycles++;
                end
                if (write && !read) begin
                    if (address == 3'd3) m_scratch = writedata;
                    if (address == 3'd7) m_freeze  = writedata[1];
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clock);
            if (started) begin
                check32("rdv_cycle", {31'b0, readdatavalid}, {31'b0, exp_rdv});
                if (exp_known) check32("rdata_cycle", readdata, exp_data);
            end
        end
    end

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] wd);
        address = a; write = 1'b1; writedata = wd;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : driver
        logic [31:0] d, a0, s0, d4, d5, d6, d7;
        reset = 1'b1; address = '0; read = 0; write = 0; writedata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        started = 1;
        check32("reset_rdv", {31'b0, readdatavalid}, 32'd0);
        check32("reset_rdata", readdata, 32'd0);

        // identity words
        do_read(3'd0, d); check32("sysid", d, 32'h0000_0000);
        do_read(3'd1, d); check32("timestamp", d, 32'd1485236220);
        do_read(3'd2, d); check32("version", d, 32'h0001_0000);
        @(negedge clock);
        check32("rdata_held", readdata, 32'h0001_0000);

        // scratch and read-only word
        do_write(3'd3, 32'hA5A5_5A5A);
        do_read(3'd3, d); check32("scratch", d, 32'hA5A5_5A5A);
        do_write(3'd0, 32'h1111_2222);
        do_read(3'd0, d); check32("sysid_ro", d, 32'h0000_0000);

        // seconds after 35 cycles from reset
        do_reset();
        repeat (35) @(negedge clock);
        do_read(3'd6, d); check32("seconds_35", d, 32'd3);

        // freeze holds uptime and seconds
        do_write(3'd7, 32'h2);
        do_read(3'd4, a0);
        do_read(3'd6, s0);
        repeat (50) @(negedge clock);
        do_read(3'd4, d); check32("freeze_uptime", d, a0);
        do_read(3'd6, d); check32("freeze_seconds", d, s0);
        do_read(3'd7, d); check32("freeze_bit", d, 32'h2);

        // clear pulse, then back-to-back reads
        do_write(3'd7, 32'h1);
        address = 3'd4; read = 1'b1;
        @(negedge clock); address = 3'd5; d4 = readdata;
        @(negedge clock); address = 3'd6; d5 = readdata;
        @(negedge clock); address = 3'd7; d6 = readdata;
        @(negedge clock); read = 1'b0;    d7 = readdata;
        check32("clr_uptime", d4, 32'd0);
        check32("clr_shadow", d5, 32'd0);
        check32("clr_seconds", d6, 32'd0);
        check32("clr_ctrl", d7, 32'd0);
        do_read(3'd4, d); check32("uptime_after_clr", d, 32'd4);

        // atomic read across the 40-bit wrap, via backdoor
        force dut.r_uptime = 40'hFF_FFFF_FFFF;
        force_req++;
        address = 3'd4; read = 1'b1;
        @(negedge clock);
        release dut.r_uptime;
        check32("atomic_lo", readdata, 32'hFFFF_FFFF);
        address = 3'd5;
        @(negedge clock);
        read = 1'b0;
        check32("atomic_hi", readdata, 32'h0000_00FF);
        @(negedge clock);
        do_read(3'd5, d); check32("shadow_stable", d, 32'h0000_00FF);
        do_write(3'd7, 32'h1);

        // read and write same cycle
        do_write(3'd3, 32'h1234_5678);
        address = 3'd3; read = 1'b1; write = 1'b1; writedata = 32'hDEAD_BEEF;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        check32("rw_old", readdata, 32'h1234_5678);
        do_read(3'd3, d); check32("rw_unchanged", d, 32'h1234_5678);

        // reset during a pending read
        address = 3'd6; read = 1'b1;
        #2 reset = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check32("midreset_rdv", {31'b0, readdatavalid}, 32'd0);
        @(negedge clock);
        check32("midreset_rdv2", {31'b0, readdatavalid}, 32'd0);
        reset = 1'b0;
        do_read(3'd4, d); check32("rst_uptime", d, 32'd0);
        do_read(3'd5, d); check32("rst_shadow", d, 32'd0);
        do_read(3'd6, d); check32("rst_seconds", d, 32'd0);
        do_read(3'd3, d); check32("rst_scratch", d, 32'd0);
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
